// File: rtl/stopwatch_core_if.sv
// Control/display bundle between the stopwatch core and its environment:
// tick and button inputs in, registered time and status out.
interface stopwatch_core_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_btn;
    logic       clear_btn;
    logic       adj;
    logic       sel;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       running;
    logic       blink;

    modport master (
        output tick_1hz, tick_2hz, pause_btn, clear_btn, adj, sel,
        input  minutes, seconds, running, blink
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_btn, clear_btn, adj, sel,
        output minutes, seconds, running, blink
    );
endinterface

// File: rtl/stopwatch_core.sv
// Minutes:seconds stopwatch with run/pause, clear and a per-field adjust mode.
// All decisions are taken from the current state and the inputs sampled at the same edge.
module stopwatch_core #(
    parameter int MAX_MIN = 59
) (
    input logic             clk,
    input logic             rst,
    stopwatch_core_if.slave sw
);
    typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;

    localparam logic [7:0] MAX_M = 8'(MAX_MIN);
    localparam logic [7:0] MAX_S = 8'd59;

    state_t     state, state_nxt;
    logic       pause_prev, clear_prev;
    logic       pause_edge, clear_edge;
    logic [7:0] min_q, sec_q, min_nxt, sec_nxt;
    logic       blink_q, blink_nxt, running_q;

    function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] top);
        return (v >= top) ? 8'd0 : v + 8'd1;
    endfunction

    assign pause_edge = sw.pause_btn & ~pause_prev;
    assign clear_edge = sw.clear_btn & ~clear_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PAUSED;
            pause_prev <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            state      <= state_nxt;
            pause_prev <= sw.pause_btn;
            clear_prev <= sw.clear_btn;
        end
    end

    // adj dominates; pause edges are only honoured outside adjust mode
    always_comb begin
        state_nxt = state;
        if (sw.adj) begin
            state_nxt = ADJUST;
        end else begin
            case (state)
                ADJUST:  state_nxt = PAUSED;
                RUN:     state_nxt = pause_edge ? PAUSED : RUN;
                PAUSED:  state_nxt = pause_edge ? RUN : PAUSED;
                default: state_nxt = PAUSED;
            endcase
        end
    end

    always_comb begin
        min_nxt   = min_q;
        sec_nxt   = sec_q;
        blink_nxt = 1'b0;
        if (clear_edge) begin
            min_nxt = 8'd0;
            sec_nxt = 8'd0;
        end else if (state == RUN && sw.tick_1hz) begin
            sec_nxt = inc_wrap(sec_q, MAX_S);
            if (sec_q >= MAX_S)
                min_nxt = inc_wrap(min_q, MAX_M);
        end else if (state == ADJUST && sw.tick_2hz) begin
            if (sw.sel)
                sec_nxt = inc_wrap(sec_q, MAX_S);
            else
                min_nxt = inc_wrap(min_q, MAX_M);
        end
        // blink only survives while staying in adjust mode
        if (state == ADJUST && sw.adj)
            blink_nxt = blink_q ^ sw.tick_2hz;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q     <= 8'd0;
            sec_q     <= 8'd0;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            min_q     <= min_nxt;
            sec_q     <= sec_nxt;
            blink_q   <= blink_nxt;
            running_q <= (state_nxt == RUN);
        end
    end

    assign sw.minutes = min_q;
    assign sw.seconds = sec_q;
    assign sw.running = running_q;
    assign sw.blink   = blink_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a time-in-seconds reference model compared every
// cycle, plus literal expectations at the key scenario points.
module tb_stopwatch_core;
    localparam int MAX_MIN = 59;

    logic clk = 1'b0;
    logic rst = 1'b1;
    stopwatch_core_if sw();

    stopwatch_core #(.MAX_MIN(MAX_MIN)) dut (.clk(clk), .rst(rst), .sw(sw));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // reference model: 0 = paused, 1 = running, 2 = adjusting
    int m_mode, m_min, m_sec;
    bit m_blink, m_pp, m_pc;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_min = 0; m_sec = 0; m_blink = 0; m_pp = 0; m_pc = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("model_minutes", int'(sw.minutes), m_min);
            chk("model_seconds", int'(sw.seconds), m_sec);
            chk("model_running", int'(sw.running), (m_mode == 1) ? 1 : 0);
            chk("model_blink",   int'(sw.blink),   int'(m_blink));
        end
    end

    task automatic step(input bit p, input bit c, input bit t1, input bit t2,
                        input bit a, input bit sl);
        bit pe, ce;
        int nm, ns, nmode, tot;
        bit nb;
        sw.pause_btn = p; sw.clear_btn = c; sw.tick_1hz = t1;
        sw.tick_2hz = t2; sw.adj = a; sw.sel = sl;
        pe = p && !m_pp;
        ce = c && !m_pc;
        nm = m_min; ns = m_sec;
        if (ce) begin
            nm = 0; ns = 0;
        end else if (m_mode == 1 && t1) begin
            tot = (m_min * 60 + m_sec + 1) % ((MAX_MIN + 1) * 60);
            nm = tot / 60; ns = tot % 60;
        end else if (m_mode == 2 && t2) begin
            if (sl) ns = (m_sec + 1) % 60;
            else    nm = (m_min + 1) % (MAX_MIN + 1);
        end
        nb = (m_mode == 2 && a) ? (m_blink ^ t2) : 1'b0;
        if (a)               nmode = 2;
        else if (m_mode == 2) nmode = 0;
        else if (pe)         nmode = (m_mode == 1) ? 0 : 1;
        else                 nmode = m_mode;
        @(posedge clk);
        m_min = nm; m_sec = ns; m_blink = nb; m_mode = nmode; m_pp = p; m_pc = c;
        #1;
    endtask

    task automatic set_time(input int mn, input int sc);
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < mn; i++) step(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < sc; i++) step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic go_run();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit(input string tag, input int mn, input int sc, input int run);
        chk({tag, "_min"}, int'(sw.minutes), mn);
        chk({tag, "_sec"}, int'(sw.seconds), sc);
        chk({tag, "_run"}, int'(sw.running), run);
    endtask

    initial begin
        sw.pause_btn = 0; sw.clear_btn = 0; sw.tick_1hz = 0;
        sw.tick_2hz = 0; sw.adj = 0; sw.sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 0, 0, 0);
        chk("reset_blink", int'(sw.blink), 0);
        rst = 0;
        cmp_en = 1;

        // run and count three seconds; 2 Hz ticks must not count outside adjust
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        lit("count3", 0, 3, 1);

        // minute carry and full wrap
        set_time(0, 59);
        go_run();
        step(0, 0, 1, 0, 0, 0);
        lit("carry", 1, 0, 1);
        set_time(59, 59);
        go_run();
        step(0, 0, 1, 0, 0, 0);
        lit("wrap", 0, 0, 1);

        // pause edge with coincident tick still counts; later ticks ignored
        set_time(0, 10);
        go_run();
        step(1, 0, 1, 0, 0, 0);
        lit("pause_tick", 0, 11, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        lit("paused_hold", 0, 11, 0);

        // seconds adjust wraps without carry, blink toggles per 2 Hz tick
        set_time(0, 58);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 1, 1, 1, 1);
        chk("adj_blink1", int'(sw.blink), 1);
        step(0, 0, 0, 1, 1, 1);
        chk("adj_blink2", int'(sw.blink), 0);
        step(0, 0, 0, 1, 1, 1);
        chk("adj_blink3", int'(sw.blink), 1);
        lit("adj_sec", 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("adj_exit_blink", int'(sw.blink), 0);
        lit("adj_exit", 0, 1, 0);

        // minutes adjust wraps at MAX_MIN
        set_time(MAX_MIN + 1, 0);
        lit("min_wrap", 0, 0, 0);

        // clear beats a simultaneous tick and keeps running
        set_time(5, 30);
        go_run();
        step(0, 1, 1, 0, 0, 0);
        lit("clear", 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        lit("after_clear", 0, 1, 1);

        // asynchronous reset mid-cycle
        set_time(12, 34);
        go_run();
        lit("pre_areset", 12, 34, 1);
        #2 rst = 1;
        #1;
        lit("areset", 0, 0, 0);
        chk("areset_blink", int'(sw.blink), 0);
        model_reset();

        // release reset while pause is held: first sample is an edge
        sw.pause_btn = 1;
        @(posedge clk);
        #1 rst = 0;
        step(1, 0, 0, 0, 0, 0);
        lit("held_btn", 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        lit("held_count", 0, 1, 1);

        @(negedge clk);
        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
